// File: rtl/mem_host_loader.sv
// mem_host_loader: streams a program into instruction memory, runs the cpu for a set
// number of cycles, then reads a data-memory window back out on a valid/ready stream.
module mem_host_loader #(
  parameter int IMEM_WORDS = 128,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] prog_len,
  input  logic [31:0] run_cycles,
  input  logic [15:0] dump_len,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        cpu_arst_n,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        busy,
  output logic        done,
  output logic        error
);
  localparam logic [15:0] IMAX = 16'(IMEM_WORDS);
  localparam logic [15:0] DMAX = 16'(DMEM_WORDS);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, RD, CAP, HOLD, DONE} state_t;
  state_t state, nxt;
  logic [15:0] plen, dlen, k, j, n_plen, n_dlen, n_k, n_j;
  logic [31:0] cnt, n_cnt, n_wdata;
  logic [63:0] n_addr, n_addr2, n_out_data;
  logic go, bad, acc, oacc;
  logic n_in_ready, n_out_valid, n_arst_n, n_enable, n_wen, n_ren2, n_busy, n_done, n_error;
  assign ren_ext = 1'b0;
  assign wen_ext_2 = 1'b0;
  assign wdata_ext_2 = 64'd0;
  assign go = start && (state == IDLE || state == DONE);
  assign bad = prog_len == 16'd0 || prog_len > IMAX || dump_len > DMAX;
  assign acc = state == LOAD && in_valid && in_ready;
  assign oacc = state == HOLD && out_valid && out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      plen <= 16'd0;
      dlen <= 16'd0;
      k <= 16'd0;
      j <= 16'd0;
      cnt <= 32'd0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= 64'd0;
      cpu_arst_n <= 1'b0;
      cpu_enable <= 1'b0;
      addr_ext <= 64'd0;
      wen_ext <= 1'b0;
      wdata_ext <= 32'd0;
      addr_ext_2 <= 64'd0;
      ren_ext_2 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= nxt;
      plen <= n_plen;
      dlen <= n_dlen;
      k <= n_k;
      j <= n_j;
      cnt <= n_cnt;
      in_ready <= n_in_ready;
      out_valid <= n_out_valid;
      out_data <= n_out_data;
      cpu_arst_n <= n_arst_n;
      cpu_enable <= n_enable;
      addr_ext <= n_addr;
      wen_ext <= n_wen;
      wdata_ext <= n_wdata;
      addr_ext_2 <= n_addr2;
      ren_ext_2 <= n_ren2;
      busy <= n_busy;
      done <= n_done;
      error <= n_error;
    end
  end
  // RUN with an exhausted counter is also the one-cycle gap after the last write
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = go ? (bad ? DONE : LOAD) : state;
      LOAD: nxt = acc && k == plen - 16'd1 ? RUN : LOAD;
      RUN: nxt = cnt != 32'd0 ? RUN : (dlen != 16'd0 ? RD : DONE);
      RD: nxt = CAP;
      CAP: nxt = HOLD;
      HOLD: nxt = oacc ? (j == dlen - 16'd1 ? DONE : RD) : HOLD;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    n_plen = go ? prog_len : plen;
    n_dlen = go ? dump_len : dlen;
    n_cnt = go ? run_cycles : (state == RUN && cnt != 32'd0 ? cnt - 32'd1 : cnt);
    n_k = go ? 16'd0 : (acc ? k + 16'd1 : k);
    n_j = go ? 16'd0 : (oacc ? j + 16'd1 : j);
    n_in_ready = nxt == LOAD;
    n_wen = acc;
    n_addr = acc ? {46'd0, k, 2'b00} : addr_ext;
    n_wdata = acc ? in_data : wdata_ext;
    n_arst_n = state == RUN || (cpu_arst_n && !go && state != IDLE);
    n_enable = state == RUN && cnt != 32'd0;
    n_ren2 = nxt == RD;
    n_addr2 = nxt == RD ? {45'd0, n_j, 3'b000} : addr_ext_2;
    n_out_valid = nxt == HOLD;
    n_out_data = state == CAP ? rdata_ext_2 : out_data;
    n_busy = nxt != IDLE && nxt != DONE;
    n_done = nxt == DONE;
    n_error = go ? bad : error;
  end
endmodule

// File: tb/tb_mem_host_loader.sv
// tb_mem_host_loader: directed stimulus with a write/dump scoreboard and a negedge monitor
module tb_mem_host_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [15:0] prog_len = 16'd0, dump_len = 16'd0;
  logic [31:0] run_cycles = 32'd0, in_data = 32'd0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, cpu_arst_n, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic busy, done, error;
  logic [63:0] out_data, addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic [31:0] wdata_ext;
  logic [63:0] mem [0:63];
  logic [95:0] wq [$];
  logic [63:0] oq [$];
  int s_cmp = 0, s_err = 0, m_cmp = 0, m_err = 0;
  int cyc = 0, wen_cnt = 0, ren_cnt = 0, en_cnt = 0, wen_streak = 0, run_len = 0;

  mem_host_loader dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len), .run_cycles(run_cycles),
    .dump_len(dump_len), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext),
    .ren_ext(ren_ext), .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
    .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // data memory responder: read data valid the cycle after the strobe
  always @(posedge clk) if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[8:3]];

  function automatic bit ok(string n, logic [63:0] a, logic [63:0] e);
    if (a !== e) $display("FAIL %s: got 0x%0h, required 0x%0h", n, a, e);
    return a === e;
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    s_cmp++;
    if (!ok(n, a, e)) s_err++;
  endtask

  task automatic mchk(string n, logic [63:0] a, logic [63:0] e);
    m_cmp++;
    if (!ok(n, a, e)) m_err++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] pl, input logic [31:0] rc, input logic [15:0] dl);
    prog_len = pl;
    run_cycles = rc;
    dump_len = dl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed_word(input logic [63:0] addr, input logic [31:0] w);
    int t = 0;
    wq.push_back({addr, w});
    in_valid = 1'b1;
    in_data = w;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    tick();
  endtask

  task automatic wait_done(input int lim);
    int t = 0;
    while (!done && t < lim) begin
      @(negedge clk);
      t++;
    end
    chk("done_wait", 64'(done), 64'd1);
  endtask

  // monitor: pops the scoreboards and checks stream/strobe invariants every cycle
  initial begin
    logic [95:0] we;
    logic prev_wen, prev_en, prev_ov, prev_hold;
    int en_start, last_ren, s;
    prev_wen = 1'b0; prev_en = 1'b0; prev_ov = 1'b0; prev_hold = 1'b0;
    en_start = 0; last_ren = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (wen_ext) begin
        if (wq.size() == 0) begin
          m_cmp++; m_err++;
          $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h, required no write", addr_ext, wdata_ext);
        end else begin
          we = wq.pop_front();
          mchk("write_addr", addr_ext, we[95:32]);
          mchk("write_data", 64'(wdata_ext), 64'(we[31:0]));
        end
        wen_cnt++;
        wen_streak = prev_wen ? wen_streak + 1 : 1;
      end
      if (prev_hold) begin
        mchk("hold_valid", 64'(out_valid), 64'd1);
        mchk("hold_no_read", 64'(ren_ext_2), 64'd0);
        if (oq.size() != 0) mchk("hold_data", out_data, oq[0]);
      end
      if (out_valid && out_ready) begin
        if (oq.size() == 0) begin
          m_cmp++; m_err++;
          $display("FAIL out_unexpected: got 0x%0h, required no word", out_data);
        end else mchk("out_data", out_data, oq.pop_front());
      end
      if (ren_ext_2) begin
        ren_cnt++;
        last_ren = cyc;
      end
      if (out_valid && !prev_ov) mchk("valid_latency", 64'(cyc - last_ren), 64'd2);
      if (cpu_enable) begin
        en_cnt++;
        if (!prev_en) en_start = cyc;
        mchk("arst_with_enable", 64'(cpu_arst_n), 64'd1);
      end else if (prev_en) run_len = cyc - en_start;
      s = int'(wen_ext) + int'(ren_ext_2) + int'(cpu_enable);
      if (s != 0) mchk("strobe_exclusive", 64'(s), 64'd1);
      prev_wen = wen_ext; prev_en = cpu_enable; prev_ov = out_valid;
      prev_hold = out_valid && !out_ready;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wb, rb, eb, t;
    mem[0] = 64'hAA;
    mem[1] = 64'hBB;
    // reset
    rst = 1'b1;
    tick();
    tick();
    chk("rst_arst_n", 64'(cpu_arst_n), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ctrl", 64'({cpu_enable, in_ready, out_valid, done, error}), 64'd0);
    chk("rst_strobes", 64'({wen_ext, ren_ext, ren_ext_2, wen_ext_2}), 64'd0);
    chk("rst_addr", addr_ext | addr_ext_2, 64'd0);
    chk("rst_data", out_data | wdata_ext_2 | 64'(wdata_ext), 64'd0);
    rst = 1'b0;
    tick();
    // load only
    wb = wen_cnt; rb = ren_cnt; eb = en_cnt;
    go(16'd3, 32'd0, 16'd0);
    feed_word(64'd0, 32'h00000013);
    feed_word(64'd4, 32'h00100093);
    feed_word(64'd8, 32'h00208133);
    in_valid = 1'b0;
    wait_done(20);
    chk("a_error", 64'(error), 64'd0);
    chk("a_busy", 64'(busy), 64'd0);
    chk("a_writes", 64'(wen_cnt - wb), 64'd3);
    chk("a_write_streak", 64'(wen_streak), 64'd3);
    chk("a_no_enable", 64'(en_cnt - eb), 64'd0);
    chk("a_no_read", 64'(ren_cnt - rb), 64'd0);
    chk("a_wq_empty", 64'(wq.size()), 64'd0);
    // full sequence, with a start pulse during RUN that must be ignored
    rb = ren_cnt; eb = en_cnt;
    out_ready = 1'b1;
    oq.push_back(64'hAA);
    oq.push_back(64'hBB);
    go(16'd2, 32'd10, 16'd2);
    feed_word(64'd0, 32'h11111111);
    feed_word(64'd4, 32'h22222222);
    in_valid = 1'b0;
    go(16'd0, 32'd3, 16'd0);
    wait_done(100);
    chk("b_run_len", 64'(run_len), 64'd10);
    chk("b_enable_cycles", 64'(en_cnt - eb), 64'd10);
    chk("b_reads", 64'(ren_cnt - rb), 64'd2);
    chk("b_oq_empty", 64'(oq.size()), 64'd0);
    chk("b_busy_start_ignored", 64'(error), 64'd0);
    chk("b_final_cpu", 64'({cpu_arst_n, cpu_enable}), 64'd2);
    // backpressure on word 0
    mem[0] = 64'h0123456789ABCDEF;
    mem[1] = 64'hFEDCBA9876543210;
    rb = ren_cnt;
    out_ready = 1'b0;
    oq.push_back(64'h0123456789ABCDEF);
    oq.push_back(64'hFEDCBA9876543210);
    go(16'd1, 32'd0, 16'd2);
    feed_word(64'd0, 32'h00000033);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("c_valid_wait", 64'(out_valid), 64'd1);
    repeat (5) @(negedge clk);
    chk("c_single_read", 64'(ren_cnt - rb), 64'd1);
    chk("c_held_data", out_data, 64'h0123456789ABCDEF);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(30);
    chk("c_reads", 64'(ren_cnt - rb), 64'd2);
    chk("c_oq_empty", 64'(oq.size()), 64'd0);
    // range errors
    wb = wen_cnt; rb = ren_cnt; eb = en_cnt;
    go(16'd0, 32'd5, 16'd1);
    tick();
    chk("d0_status", 64'({busy, done, error}), 64'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("d_rst_clears", 64'({done, error}), 64'd0);
    go(16'd4, 32'd0, 16'd65);
    tick();
    chk("d1_status", 64'({busy, done, error}), 64'd3);
    chk("d1_in_ready", 64'(in_ready), 64'd0);
    chk("d_no_traffic", 64'((wen_cnt - wb) + (ren_cnt - rb) + (en_cnt - eb)), 64'd0);
    // reset in the middle of LOAD
    wb = wen_cnt;
    go(16'd4, 32'd0, 16'd0);
    feed_word(64'd0, 32'h000000A0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h000000A1;
    tick();
    chk("e_wen_off", 64'(wen_ext), 64'd0);
    chk("e_in_ready_off", 64'(in_ready), 64'd0);
    chk("e_idle", 64'({busy, cpu_arst_n}), 64'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("e_one_write", 64'(wen_cnt - wb), 64'd1);
    go(16'd2, 32'd0, 16'd0);
    feed_word(64'd0, 32'h000000B0);
    feed_word(64'd4, 32'h000000B1);
    in_valid = 1'b0;
    wait_done(20);
    chk("e_wq_empty", 64'(wq.size()), 64'd0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", s_cmp + m_cmp, s_err + m_err);
    $finish;
  end
endmodule
